fir_result_reporter: RTL

- Sits directly downstream of the FIR engine's AXI-Stream output (Y stream) inside the user project.
- Converts each output sample into a framed marker sequence on user GPIO bits mprj_io[31:16]: start mark, then per sample a separator followed by the data word, then an end mark.
- Lets the chip-level bench, or an external observer, capture FIR results without involving the management core.

---
 rtl/fir_result_reporter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fir_result_reporter.sv
// fir_result_reporter
//   Turns each sample of the FIR Y stream into a framed marker sequence on a
//   GPIO field: START_MARK, then per sample SEP_CODE followed by the data word,
//   then END_MARK. Every code is held for HOLD cycles, so a slow observer can
//   capture FIR results without help from the management core.
//
// Ports
//   wb_clk_i   clock
//   wb_rst_i   asynchronous, active-high reset
//   start      one-cycle pulse; begins a frame (accepted in IDLE or END only)
//   frame_len  samples expected in the frame, sampled on an accepted start (0 = 1024)
//   s_tvalid   stream valid from FIR
//   s_tdata    signed FIR output sample
//   s_tlast    last sample of frame
//   s_tready   high only while waiting for the next sample
//   io_out     result code field (mprj_io[31:16])
//   io_oeb     active-low output enable for the same pads
//   busy       frame in progress
//   done       one-cycle pulse on entry to END
//   len_err    sticky; tlast position disagreed with frame_len
//   sep_hit    sticky; an emitted data word equalled SEP_CODE
module fir_result_reporter #(
    parameter int                DATA_W     = 32,
    parameter int                OUT_W      = 16,
    parameter int                HOLD       = 4,
    parameter logic [OUT_W-1:0]  START_MARK = 16'hAB40,
    parameter logic [OUT_W-1:0]  END_MARK   = 16'hAB51,
    parameter logic [OUT_W-1:0]  SEP_CODE   = 16'hFFFF,
    parameter bit                SATURATE   = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [9:0]        frame_len,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [OUT_W-1:0]  io_out,
    output logic [OUT_W-1:0]  io_oeb,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              sep_hit
);

    typedef enum logic [2:0] {ST_IDLE, ST_STMK, ST_WAIT, ST_SEP, ST_DATA, ST_END} state_t;

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t            state, state_nx;
    logic [HW-1:0]     hold_cnt;
    logic [9:0]        smp_cnt;
    logic [9:0]        len_q;
    logic [OUT_W-1:0]  data_q;
    logic              last_q;

    logic              hold_done;
    logic              hs;
    logic              start_acc;
    logic [9:0]        cnt_inc;
    logic              hit_len;
    logic [OUT_W-1:0]  conv;

    assign hold_done = (hold_cnt == HW'(HOLD - 1));
    assign s_tready  = (state == ST_WAIT);
    assign busy      = (state == ST_STMK) || (state == ST_WAIT) ||
                       (state == ST_SEP)  || (state == ST_DATA);
    assign hs        = s_tvalid && s_tready;
    assign start_acc = start && ((state == ST_IDLE) || (state == ST_END));
    // 10-bit wrap makes frame_len = 0 terminate on the 1024th sample.
    assign cnt_inc   = smp_cnt + 10'd1;
    assign hit_len   = (cnt_inc == len_q);

    generate
        if (SATURATE) begin : g_sat
            localparam logic signed [DATA_W-1:0] MAX_V = DATA_W'((1 << (OUT_W - 1)) - 1);
            localparam logic signed [DATA_W-1:0] MIN_V = ~MAX_V;
            always_comb begin
                conv = s_tdata[OUT_W-1:0];
                if ($signed(s_tdata) > MAX_V)
                    conv = {1'b0, {(OUT_W-1){1'b1}}};
                else if ($signed(s_tdata) < MIN_V)
                    conv = {1'b1, {(OUT_W-1){1'b0}}};
            end
        end else begin : g_trunc
            assign conv = s_tdata[OUT_W-1:0];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start)     state_nx = ST_STMK;
            ST_STMK: if (hold_done) state_nx = ST_WAIT;
            ST_WAIT: if (s_tvalid)  state_nx = ST_SEP;
            ST_SEP:  if (hold_done) state_nx = ST_DATA;
            ST_DATA: if (hold_done) state_nx = last_q ? ST_END : ST_WAIT;
            ST_END:  if (start)     state_nx = ST_STMK;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            smp_cnt  <= '0;
            len_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            io_out   <= '0;
            io_oeb   <= '1;
            done     <= 1'b0;
            len_err  <= 1'b0;
            sep_hit  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state_nx == ST_END) && (state != ST_END);

            if (state_nx != state)
                hold_cnt <= '0;
            else if ((state == ST_STMK) || (state == ST_SEP) || (state == ST_DATA))
                hold_cnt <= hold_cnt + 1'b1;

            // Pads stay enabled from the first accepted start until reset.
            if (start_acc) begin
                io_oeb  <= '0;
                len_q   <= frame_len;
                smp_cnt <= '0;
                len_err <= 1'b0;
                sep_hit <= 1'b0;
            end

            if (hs) begin
                data_q  <= conv;
                smp_cnt <= cnt_inc;
                // Either terminator ends the frame; disagreement is flagged.
                last_q  <= s_tlast || hit_len;
                if (s_tlast != hit_len)
                    len_err <= 1'b1;
            end

            // The word goes out unchanged; the flag lets the observer
            // resolve the separator/data ambiguity.
            if ((state == ST_SEP) && hold_done && (data_q == SEP_CODE))
                sep_hit <= 1'b1;

            // Registered output: the code selected by the current state
            // appears one cycle after the state is entered.
            case (state)
                ST_IDLE: io_out <= '0;
                ST_STMK: io_out <= START_MARK;
                ST_SEP:  io_out <= SEP_CODE;
                ST_DATA: io_out <= data_q;
                ST_END:  io_out <= END_MARK;
                default: io_out <= io_out;
            endcase
        end
    end

endmodule
